dmem_unit: RTL and testbench

//  Parametrised data-memory unit for the MEM stage, replacing the bare dmem array.

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_unit.sv | 169 ++++++++++++++++
 tb/tb_dmem_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the data-memory unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle completion pulse.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [0:2]  req_info;
    logic [0:31] req_addr;
    logic [0:31] req_wdata;
    logic        resp_valid;
    logic [0:31] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_info, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_info, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_unit.sv
// Big-endian byte-addressed data memory with configurable latency, load extension,
// store lane placement and rejection of misaligned/invalid/out-of-range accesses.
module dmem_unit #(
    parameter int ADDR_W  = 15,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    dmem_if.slave      bus,
    output logic       busy,
    output logic [1:0] dbg_state_o
);
    localparam int unsigned MEM_BYTES = 1 << ADDR_W;
    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        write_q, zext_q;
    logic [1:0]  dsize_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [7:0]  mem [MEM_BYTES];

    logic        accept, commit, use_live;
    logic        op_write, op_zext, op_err;
    logic [1:0]  op_dsize;
    logic [31:0] op_addr, op_wdata, load_data;
    logic [2:0]  nbytes;
    logic [32:0] last_addr;
    logic [ADDR_W-1:0] idx0, idx1, idx2, idx3;
    logic [7:0]  b0, b1, b2, b3;

    assign accept = bus.req_valid && bus.req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.req_ready  = (state_q == IDLE) || (state_q == RESP);
        bus.resp_valid = (state_q == RESP);
        busy           = (state_q == WAIT);
        dbg_state_o    = state_q;
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= bus.req_write;
            zext_q  <= bus.req_info[0];
            dsize_q <= {bus.req_info[1], bus.req_info[2]};
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // With LATENCY==1 the commit edge is the accept edge, so operands come straight from the port.
    assign use_live = (state_q != WAIT);
    assign commit   = (state_d == RESP);
    assign op_write = use_live ? bus.req_write : write_q;
    assign op_zext  = use_live ? bus.req_info[0] : zext_q;
    assign op_dsize = use_live ? {bus.req_info[1], bus.req_info[2]} : dsize_q;
    assign op_addr  = use_live ? bus.req_addr : addr_q;
    assign op_wdata = use_live ? bus.req_wdata : wdata_q;

    always_comb begin
        unique case (op_dsize)
            2'b11:   nbytes = 3'd4;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd1;
        endcase
        last_addr = {1'b0, op_addr} + 33'(nbytes) - 33'd1;
        op_err = (op_dsize == 2'b10)
              || (op_dsize == 2'b01 && op_addr[0])
              || (op_dsize == 2'b11 && op_addr[1:0] != 2'b00)
              || (last_addr >= 33'(MEM_BYTES));
    end

    assign idx0 = op_addr[ADDR_W-1:0];
    assign idx1 = idx0 + 1'b1;
    assign idx2 = idx0 + 2'd2;
    assign idx3 = idx0 + 2'd3;
    assign b0   = mem[idx0];
    assign b1   = mem[idx1];
    assign b2   = mem[idx2];
    assign b3   = mem[idx3];

    always_comb begin
        unique case (op_dsize)
            2'b11:   load_data = {b0, b1, b2, b3};
            2'b01:   load_data = {{16{~op_zext & b0[7]}}, b0, b1};
            default: load_data = {{24{~op_zext & b0[7]}}, b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= op_err;
            rdata_q <= (op_err || op_write) ? 32'd0 : load_data;
        end
    end

    // Memory is never reset; a store discarded by reset never reaches here.
    always_ff @(posedge clk) begin
        if (!reset && commit && op_write && !op_err) begin
            unique case (op_dsize)
                2'b11: begin
                    mem[idx0] <= op_wdata[31:24];
                    mem[idx1] <= op_wdata[23:16];
                    mem[idx2] <= op_wdata[15:8];
                    mem[idx3] <= op_wdata[7:0];
                end
                2'b01: begin
                    mem[idx0] <= op_wdata[15:8];
                    mem[idx1] <= op_wdata[7:0];
                end
                default: mem[idx0] <= op_wdata[7:0];
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: a LATENCY=3 instance for timing, errors and reset abort,
// and a LATENCY=1 instance for back-to-back streaming.
module tb_dmem_unit;
    localparam int ADDR_W    = 15;
    localparam int MEM_BYTES = 1 << ADDR_W;

    logic       clk = 1'b0;
    logic       rst3, rst1;
    logic       busy3, busy1;
    logic [1:0] st3, st1;
    int         n_checks = 0;
    int         n_pass   = 0;

    byte unsigned ref_mem [MEM_BYTES];
    logic [31:0]  exp_q [$];

    dmem_if bus3();
    dmem_if bus1();

    dmem_unit #(.ADDR_W(ADDR_W), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset(rst3), .bus(bus3), .busy(busy3), .dbg_state_o(st3)
    );
    dmem_unit #(.ADDR_W(ADDR_W), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst1), .bus(bus1), .busy(busy1), .dbg_state_o(st1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: plain byte array and arithmetic on access size.
    task automatic model_op(input bit wr, input bit zext, input logic [1:0] dsize,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic err, output logic [31:0] rdata);
        longint a, v;
        int nb;
        a  = longint'(addr);
        nb = (dsize == 2'b11) ? 4 : (dsize == 2'b01) ? 2 : 1;
        err = (dsize == 2'b10) || (a % nb != 0) || (a + nb > MEM_BYTES);
        rdata = 32'd0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < nb; i++)
                    ref_mem[a + i] = 8'(wdata >> (8 * (nb - 1 - i)));
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v * 256 + longint'(ref_mem[a + i]);
                if (!zext && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                    v = v - (longint'(1) << (8 * nb));
                rdata = 32'(v);
            end
        end
    endtask

    // Drives one request on the LATENCY=3 port from a sample point and waits for its response.
    task automatic do_op3(input bit wr, input bit zext, input logic [1:0] dsize,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output bit ready_ok, output int lat, output logic err,
                          output logic [31:0] rdata, output int busy_cycles);
        ready_ok        = bus3.req_ready;
        bus3.req_valid  = 1'b1;
        bus3.req_write  = wr;
        bus3.req_info   = {zext, dsize};
        bus3.req_addr   = addr;
        bus3.req_wdata  = wdata;
        @(posedge clk); #1;
        bus3.req_valid  = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!bus3.resp_valid && lat < 40) begin
            if (busy3) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus3.resp_valid) lat = -1;
        err   = bus3.resp_err;
        rdata = bus3.resp_rdata;
    endtask

    task automatic test_reset();
        rst3 = 1'b1; rst1 = 1'b1;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_info = 3'b0;
        bus3.req_addr = 32'd0; bus3.req_wdata = 32'd0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_info = 3'b0;
        bus1.req_addr = 32'd0; bus1.req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus3.resp_valid !== 1'b0) $display("FAIL reset_resp_valid3: got %b want 0", bus3.resp_valid); else n_pass++;
        n_checks++; if (bus3.resp_rdata !== 32'd0) $display("FAIL reset_rdata3: got %h want 0", bus3.resp_rdata); else n_pass++;
        n_checks++; if (bus3.resp_err !== 1'b0) $display("FAIL reset_err3: got %b want 0", bus3.resp_err); else n_pass++;
        n_checks++; if (busy3 !== 1'b0) $display("FAIL reset_busy3: got %b want 0", busy3); else n_pass++;
        n_checks++; if (bus3.req_ready !== 1'b1) $display("FAIL reset_ready3: got %b want 1", bus3.req_ready); else n_pass++;
        n_checks++; if (bus1.resp_valid !== 1'b0) $display("FAIL reset_resp_valid1: got %b want 0", bus1.resp_valid); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b want 0", busy1); else n_pass++;
        rst3 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_store_load_timing();
        bit rdy; int lat, bc; logic err; logic [31:0] rd;
        do_op3(1'b1, 1'b0, 2'b11, 32'h100, 32'hDEADBEEF, rdy, lat, err, rd, bc);
        n_checks++; if (rdy !== 1'b1) $display("FAIL t1_ready: got %b want 1", rdy); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL t1_latency: got %0d want 3", lat); else n_pass++;
        n_checks++; if (bc != 2) $display("FAIL t1_busy_cycles: got %0d want 2", bc); else n_pass++;
        n_checks++; if (busy3 !== 1'b0) $display("FAIL t1_busy_in_resp: got %b want 0", busy3); else n_pass++;
        n_checks++; if (err !== 1'b0 || rd !== 32'd0) $display("FAIL t1_store_resp: got err=%b rdata=%h want err=0 rdata=0", err, rd); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus3.resp_valid !== 1'b0) $display("FAIL t1_pulse_width: got %b want 0", bus3.resp_valid); else n_pass++;
        do_op3(1'b0, 1'b0, 2'b11, 32'h100, 32'd0, rdy, lat, err, rd, bc);
        n_checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) $display("FAIL t1_word_load: got %h err=%b want deadbeef err=0", rd, err); else n_pass++;
    endtask

    task automatic test_load_ext();
        bit rdy; int lat, bc; logic err; logic [31:0] rd;
        do_op3(1'b0, 1'b0, 2'b00, 32'h101, 32'd0, rdy, lat, err, rd, bc);
        n_checks++; if (rd !== 32'hFFFFFFAD) $display("FAIL t2_lb_signed: got %h want ffffffad", rd); else n_pass++;
        do_op3(1'b0, 1'b1, 2'b00, 32'h101, 32'd0, rdy, lat, err, rd, bc);
        n_checks++; if (rd !== 32'h000000AD) $display("FAIL t2_lb_unsigned: got %h want 000000ad", rd); else n_pass++;
        do_op3(1'b0, 1'b0, 2'b01, 32'h102, 32'd0, rdy, lat, err, rd, bc);
        n_checks++; if (rd !== 32'hFFFFBEEF) $display("FAIL t2_lh_signed: got %h want ffffbeef", rd); else n_pass++;
        do_op3(1'b0, 1'b1, 2'b01, 32'h100, 32'd0, rdy, lat, err, rd, bc);
        n_checks++; if (rd !== 32'h0000DEAD) $display("FAIL t2_lh_unsigned: got %h want 0000dead", rd); else n_pass++;
    endtask

    task automatic test_half_store();
        bit rdy; int lat, bc; logic err; logic [31:0] rd;
        do_op3(1'b1, 1'b0, 2'b01, 32'h102, 32'hAAAA1234, rdy, lat, err, rd, bc);
        n_checks++; if (err !== 1'b0 || rd !== 32'd0) $display("FAIL t3_sh_resp: got err=%b rdata=%h want 0/0", err, rd); else n_pass++;
        do_op3(1'b0, 1'b0, 2'b11, 32'h100, 32'd0, rdy, lat, err, rd, bc);
        n_checks++; if (rd !== 32'hDEAD1234) $display("FAIL t3_word_after_sh: got %h want dead1234", rd); else n_pass++;
    endtask

    task automatic test_errors();
        bit rdy; int lat, bc; logic err; logic [31:0] rd;
        bit          wr_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  ds_t [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
        logic [31:0] ad_t [4] = '{32'h102, 32'h103, 32'h100, 32'h8000};
        for (int i = 0; i < 4; i++) begin
            do_op3(wr_t[i], 1'b0, ds_t[i], ad_t[i], 32'hFFFFFFFF, rdy, lat, err, rd, bc);
            n_checks++; if (err !== 1'b1) $display("FAIL t4_err_%0d: got %b want 1", i, err); else n_pass++;
            n_checks++; if (rd !== 32'd0) $display("FAIL t4_rdata_%0d: got %h want 0", i, rd); else n_pass++;
            n_checks++; if (lat != 3) $display("FAIL t4_latency_%0d: got %0d want 3", i, lat); else n_pass++;
        end
        do_op3(1'b0, 1'b0, 2'b11, 32'h100, 32'd0, rdy, lat, err, rd, bc);
        n_checks++; if (rd !== 32'hDEAD1234 || err !== 1'b0) $display("FAIL t4_reread: got %h err=%b want dead1234 err=0", rd, err); else n_pass++;
    endtask

    task automatic test_reset_abort();
        bit rdy; int lat, bc; logic err; logic [31:0] rd; int seen;
        do_op3(1'b1, 1'b0, 2'b00, 32'h200, 32'h00000011, rdy, lat, err, rd, bc);
        bus3.req_valid = 1'b1; bus3.req_write = 1'b1; bus3.req_info = 3'b000;
        bus3.req_addr = 32'h200; bus3.req_wdata = 32'h00000055;
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        n_checks++; if (busy3 !== 1'b1) $display("FAIL t5_in_wait: got busy=%b want 1", busy3); else n_pass++;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        n_checks++; if (bus3.req_ready !== 1'b1) $display("FAIL t5_ready_after_reset: got %b want 1", bus3.req_ready); else n_pass++;
        seen = bus3.resp_valid ? 1 : 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus3.resp_valid) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL t5_no_resp: got %0d resp_valid cycles want 0", seen); else n_pass++;
        do_op3(1'b0, 1'b1, 2'b00, 32'h200, 32'd0, rdy, lat, err, rd, bc);
        n_checks++; if (rd !== 32'h00000011) $display("FAIL t5_old_value: got %h want 00000011", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4];
        logic [31:0] exp_v;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (bus1.req_ready !== 1'b1) $display("FAIL t6_ready_%0d: got %b want 1", k, bus1.req_ready); else n_pass++;
            bus1.req_valid = 1'b1;
            bus1.req_write = (k < 4);
            bus1.req_info  = 3'b011;
            bus1.req_addr  = 32'h100 + 32'(4 * (k % 4));
            bus1.req_wdata = w[k % 4];
            exp_q.push_back((k < 4) ? 32'd0 : w[k % 4]);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (bus1.resp_valid !== 1'b1 || bus1.resp_err !== 1'b0 || bus1.resp_rdata !== exp_v)
                $display("FAIL t6_resp_%0d: got v=%b e=%b d=%h want v=1 e=0 d=%h", k, bus1.resp_valid, bus1.resp_err, bus1.resp_rdata, exp_v);
            else n_pass++;
        end
        bus1.req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus1.resp_valid !== 1'b0) $display("FAIL t6_idle: got %b want 0", bus1.resp_valid); else n_pass++;
    endtask

    task automatic test_random();
        bit rdy; int lat, bc; logic err, e_err; logic [31:0] rd, e_rd, addr, wd;
        bit wr, zx; logic [1:0] ds;
        for (int i = 0; i < 20; i++) begin
            addr = (i < 16) ? 32'h300 + 32'(4 * i) : 32'h7FF0 + 32'(4 * (i - 16));
            wd = $urandom;
            model_op(1'b1, 1'b0, 2'b11, addr, wd, e_err, e_rd);
            do_op3(1'b1, 1'b0, 2'b11, addr, wd, rdy, lat, err, rd, bc);
            n_checks++; if (err !== e_err) $display("FAIL rnd_fill_%0d: got err=%b want %b", i, err, e_err); else n_pass++;
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) addr = 32'h7FF0 + 32'($urandom_range(0, 19));
            else addr = 32'h300 + 32'($urandom_range(0, 63));
            wr = ($urandom_range(0, 2) == 0);
            zx = 1'($urandom_range(0, 1));
            ds = 2'($urandom_range(0, 3));
            wd = $urandom;
            model_op(wr, zx, ds, addr, wd, e_err, e_rd);
            do_op3(wr, zx, ds, addr, wd, rdy, lat, err, rd, bc);
            n_checks++; if (err !== e_err) $display("FAIL rnd_err_%0d: addr=%h ds=%b got %b want %b", i, addr, ds, err, e_err); else n_pass++;
            n_checks++; if (rd !== e_rd) $display("FAIL rnd_rdata_%0d: addr=%h ds=%b got %h want %h", i, addr, ds, rd, e_rd); else n_pass++;
            n_checks++; if (lat != 3) $display("FAIL rnd_latency_%0d: got %0d want 3", i, lat); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_store_load_timing();
        test_load_ext();
        test_half_store();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
